// File: rtl/control_unit_mc.sv
// Multi-cycle control FSM for the 16BitNotRISC datapath.
// Fetches, decodes and executes one instruction at a time; control outputs are registered.
module control_unit_mc #(
   parameter int unsigned IW        = 16,
   parameter int unsigned RA_W      = 4,
   parameter int unsigned DA_W      = 8,
   parameter int unsigned MEM_WAIT  = 1,
   parameter logic [2:0]  ALU_ADD   = 3'h1,
   parameter logic [2:0]  ALU_SUB   = 3'h2,
   parameter logic [2:0]  ALU_PASSA = 3'h0
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [IW-1:0]   IM_DATA,
   input  logic            ALU_Z,
   output logic            PC_CLR,
   output logic            PC_IC,
   output logic            PC_LD,
   output logic [DA_W-1:0] PC_OFF,
   output logic [DA_W-1:0] D_ADDR,
   output logic            D_WR,
   output logic            RF_S,
   output logic            RF_W_EN,
   output logic [RA_W-1:0] RF_A_ADDR,
   output logic [RA_W-1:0] RF_B_ADDR,
   output logic [RA_W-1:0] RF_W_ADDR,
   output logic [2:0]      ALU_S,
   output logic            HALTED,
   output logic            ILLEGAL,
   output logic [3:0]      STATE
);

   localparam int unsigned CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_LOAD_A = 4'd3,
      S_LOAD_B = 4'd4,
      S_STORE  = 4'd5,
      S_ADD    = 4'd6,
      S_SUB    = 4'd7,
      S_JMPZ   = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   typedef struct packed {
      logic            pc_clr;
      logic            pc_ic;
      logic            jmpz;
      logic            d_wr;
      logic            rf_s;
      logic            rf_w_en;
      logic            halted;
      logic [DA_W-1:0] pc_off;
      logic [DA_W-1:0] d_addr;
      logic [RA_W-1:0] rf_a;
      logic [RA_W-1:0] rf_b;
      logic [RA_W-1:0] rf_w;
      logic [2:0]      alu_s;
   } ctrl_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ir_q, ir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   ctrl_t            ctrl_q;
   logic [3:0]       opcode;

   // Moore control decode for a given state and instruction word
   function automatic ctrl_t decode(input state_t s, input logic [IW-1:0] ir);
      ctrl_t c;
      c = '0;
      case (s)
         S_INIT:   c.pc_clr = 1'b1;
         S_DECODE: c.pc_ic  = 1'b1;
         S_LOAD_A: begin
            c.d_addr = ir[RA_W+DA_W-1:RA_W];
            c.rf_w   = ir[RA_W-1:0];
         end
         S_LOAD_B: begin
            c.d_addr  = ir[RA_W+DA_W-1:RA_W];
            c.rf_w    = ir[RA_W-1:0];
            c.rf_s    = 1'b1;
            c.rf_w_en = 1'b1;
         end
         S_STORE: begin
            c.rf_a   = ir[IW-5 -: RA_W];
            c.d_addr = ir[DA_W-1:0];
            c.d_wr   = 1'b1;
         end
         S_ADD, S_SUB: begin
            c.rf_a    = ir[IW-5 -: RA_W];
            c.rf_b    = ir[IW-5-RA_W -: RA_W];
            c.rf_w    = ir[RA_W-1:0];
            c.rf_w_en = 1'b1;
            c.alu_s   = (s == S_ADD) ? ALU_ADD : ALU_SUB;
         end
         S_JMPZ: begin
            c.rf_a   = ir[IW-5 -: RA_W];
            c.alu_s  = ALU_PASSA;
            c.pc_off = ir[DA_W-1:0];
            c.jmpz   = 1'b1;
         end
         S_HALT:   c.halted = 1'b1;
         default:  ;
      endcase
      return c;
   endfunction

   assign opcode = ir_q[IW-1 -: 4];

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH: begin
            ir_d    = IM_DATA;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               4'd0: state_d = S_FETCH;
               4'd1: state_d = S_STORE;
               4'd2: begin
                  state_d = S_LOAD_A;
                  cnt_d   = CNT_W'(MEM_WAIT - 1);
               end
               4'd3: state_d = S_ADD;
               4'd4: state_d = S_SUB;
               4'd5: state_d = S_HALT;
               4'd6: state_d = S_JMPZ;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_LOAD_A: begin
            if (cnt_q == '0) state_d = S_LOAD_B;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_LOAD_B, S_STORE, S_ADD, S_SUB, S_JMPZ: state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   // State, IR and output registers; outputs track the state being entered
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= S_INIT;
         ir_q      <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         ctrl_q    <= decode(S_INIT, IW'(0));
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         ctrl_q    <= decode(state_d, ir_d);
      end
   end

   assign PC_CLR    = ctrl_q.pc_clr;
   assign PC_IC     = ctrl_q.pc_ic;
   assign PC_LD     = ctrl_q.jmpz & ALU_Z;
   assign PC_OFF    = ctrl_q.pc_off;
   assign D_ADDR    = ctrl_q.d_addr;
   assign D_WR      = ctrl_q.d_wr;
   assign RF_S      = ctrl_q.rf_s;
   assign RF_W_EN   = ctrl_q.rf_w_en;
   assign RF_A_ADDR = ctrl_q.rf_a;
   assign RF_B_ADDR = ctrl_q.rf_b;
   assign RF_W_ADDR = ctrl_q.rf_w;
   assign ALU_S     = ctrl_q.alu_s;
   assign HALTED    = ctrl_q.halted;
   assign ILLEGAL   = illegal_q;
   assign STATE     = state_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: one instance with MEM_WAIT=1 and one with MEM_WAIT=3.
module tb_control_unit_mc;

   logic        Clock;
   logic        Reset, Reset3;
   logic [15:0] IM_DATA, IM3;
   logic        ALU_Z;

   logic       PC_CLR, PC_IC, PC_LD, D_WR, RF_S, RF_W_EN, HALTED, ILLEGAL;
   logic [7:0] PC_OFF, D_ADDR;
   logic [3:0] RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, STATE;
   logic [2:0] ALU_S;

   logic       PC_CLR3, PC_IC3, PC_LD3, D_WR3, RF_S3, RF_W_EN3, HALTED3, ILLEGAL3;
   logic [7:0] PC_OFF3, D_ADDR3;
   logic [3:0] RF_A_ADDR3, RF_B_ADDR3, RF_W_ADDR3, STATE3;
   logic [2:0] ALU_S3;

   int vectors     = 0;
   int miscompares = 0;

   control_unit_mc #(.MEM_WAIT(1)) dut (
      .Clock(Clock), .Reset(Reset), .IM_DATA(IM_DATA), .ALU_Z(ALU_Z),
      .PC_CLR(PC_CLR), .PC_IC(PC_IC), .PC_LD(PC_LD), .PC_OFF(PC_OFF),
      .D_ADDR(D_ADDR), .D_WR(D_WR), .RF_S(RF_S), .RF_W_EN(RF_W_EN),
      .RF_A_ADDR(RF_A_ADDR), .RF_B_ADDR(RF_B_ADDR), .RF_W_ADDR(RF_W_ADDR),
      .ALU_S(ALU_S), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .STATE(STATE)
   );

   control_unit_mc #(.MEM_WAIT(3)) dut3 (
      .Clock(Clock), .Reset(Reset3), .IM_DATA(IM3), .ALU_Z(ALU_Z),
      .PC_CLR(PC_CLR3), .PC_IC(PC_IC3), .PC_LD(PC_LD3), .PC_OFF(PC_OFF3),
      .D_ADDR(D_ADDR3), .D_WR(D_WR3), .RF_S(RF_S3), .RF_W_EN(RF_W_EN3),
      .RF_A_ADDR(RF_A_ADDR3), .RF_B_ADDR(RF_B_ADDR3), .RF_W_ADDR(RF_W_ADDR3),
      .ALU_S(ALU_S3), .HALTED(HALTED3), .ILLEGAL(ILLEGAL3), .STATE(STATE3)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int bad, n, la, wen;
      Reset = 1'b1; Reset3 = 1'b1; IM_DATA = '0; IM3 = '0; ALU_Z = 1'b0;
      tick(); tick();
      chk("rst_state", STATE, 0); chk("rst_pc_clr", PC_CLR, 1); chk("rst_illegal", ILLEGAL, 0);
      chk("rst_wen", RF_W_EN, 0); chk("rst_dwr", D_WR, 0);

      // LOAD r3 <- [A5]
      Reset = 1'b0; IM_DATA = 16'h2A53;
      tick(); chk("fetch_state", STATE, 1); chk("pc_clr_once", PC_CLR, 0);
      tick(); chk("decode_state", STATE, 2); chk("decode_pc_ic", PC_IC, 1);
      tick(); chk("lda_state", STATE, 3); chk("lda_addr", D_ADDR, 8'hA5);
              chk("lda_wen", RF_W_EN, 0); chk("lda_pc_ic", PC_IC, 0);
      tick(); chk("ldb_state", STATE, 4); chk("ldb_addr", D_ADDR, 8'hA5);
              chk("ldb_rfs", RF_S, 1); chk("ldb_wen", RF_W_EN, 1); chk("ldb_waddr", RF_W_ADDR, 3);
      tick(); chk("ld_done", STATE, 1); chk("ld_done_wen", RF_W_EN, 0);

      // ADD r5 <- r1 + r2
      IM_DATA = 16'h3125;
      tick(); tick();
      chk("add_state", STATE, 6); chk("add_a", RF_A_ADDR, 1); chk("add_b", RF_B_ADDR, 2);
      chk("add_w", RF_W_ADDR, 5); chk("add_alu", ALU_S, 1); chk("add_wen", RF_W_EN, 1);
      chk("add_rfs", RF_S, 0);
      tick(); chk("add_done", STATE, 1); chk("add_done_wen", RF_W_EN, 0);

      // SUB r5 <- r1 - r2
      IM_DATA = 16'h4125;
      tick(); tick();
      chk("sub_state", STATE, 7); chk("sub_alu", ALU_S, 2); chk("sub_wen", RF_W_EN, 1);
      tick(); chk("sub_done", STATE, 1);

      // JMPZ r1,-2 taken
      IM_DATA = 16'h61FE; ALU_Z = 1'b1;
      tick(); chk("jz_dec_ld", PC_LD, 0);
      tick(); chk("jz_state", STATE, 8); chk("jz_ld", PC_LD, 1); chk("jz_ic", PC_IC, 0);
              chk("jz_off", PC_OFF, 8'hFE); chk("jz_a", RF_A_ADDR, 1); chk("jz_alu", ALU_S, 0);
              chk("jz_wen", RF_W_EN, 0);
      tick(); chk("jz_done", STATE, 1); chk("jz_done_ld", PC_LD, 0);

      // JMPZ not taken
      ALU_Z = 1'b0;
      tick(); tick(); chk("jnz_state", STATE, 8); chk("jnz_ld", PC_LD, 0);
      tick(); chk("jnz_done", STATE, 1);

      // STORE r12 -> [40]
      IM_DATA = 16'h1C40;
      tick(); tick();
      chk("st_state", STATE, 5); chk("st_dwr", D_WR, 1); chk("st_a", RF_A_ADDR, 12);
      chk("st_addr", D_ADDR, 8'h40); chk("st_wen", RF_W_EN, 0);
      tick(); chk("st_done", STATE, 1); chk("st_done_dwr", D_WR, 0);

      // Illegal opcode
      IM_DATA = 16'hF000;
      tick(); chk("ill_dec", STATE, 2); chk("ill_pre", ILLEGAL, 0);
      tick(); chk("ill_state", STATE, 1); chk("ill_flag", ILLEGAL, 1);
              chk("ill_dwr", D_WR, 0); chk("ill_wen", RF_W_EN, 0);

      // NOOP keeps ILLEGAL sticky
      IM_DATA = 16'h0000;
      tick(); tick(); chk("noop_state", STATE, 1); chk("ill_sticky", ILLEGAL, 1);

      // Reset during LOAD_A aborts the load
      IM_DATA = 16'h2A53;
      tick(); tick(); chk("abort_lda", STATE, 3);
      Reset = 1'b1;
      tick(); chk("abort_state", STATE, 0); chk("abort_wen", RF_W_EN, 0);
              chk("abort_dwr", D_WR, 0); chk("abort_ill", ILLEGAL, 0);
      Reset = 1'b0; IM_DATA = 16'h5000;
      tick(); chk("rst2_fetch", STATE, 1);

      // HALT holds with no activity
      tick(); tick(); chk("halt_state", STATE, 9); chk("halt_flag", HALTED, 1);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         IM_DATA = 16'(i * 16'h1357);
         ALU_Z   = i[0];
         tick();
         if (STATE != 4'd9 || !HALTED || PC_CLR || PC_IC || PC_LD || D_WR || RF_W_EN) bad++;
      end
      chk("halt_hold", bad, 0);

      // MEM_WAIT=3 instance: LOAD takes 6 cycles FETCH to FETCH
      Reset3 = 1'b0; IM3 = 16'h2A53;
      tick(); chk("mw3_fetch", STATE3, 1);
      n = 0; la = 0; wen = 0;
      do begin
         tick();
         n++;
         if (STATE3 == 4'd3) la++;
         if (RF_W_EN3) wen++;
      end while (STATE3 != 4'd1 && n < 20);
      chk("mw3_cycles", n, 6); chk("mw3_lda_cycles", la, 3); chk("mw3_wen_cycles", wen, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
